lfsr_gen: RTL
=============

Name: lfsr_gen

Overview:
- Parametrised, maximal-length LFSR generator; successor to the fixed 8-bit Fibonacci generator.
- Runtime features: selectable length 2..WIDTH, 2- or 4-tap polynomials, Fibonacci or Galois topology.
- Control: seed load via valid/ready handshake, free-run or single-step, period-wrap flag.
- Synchronous clock enable only; no gated clocks. Sits between the tt top-level IO sampling logic and the output pin registers.

Parameters:
- WIDTH, 16, maximum LFSR length in bits; legal range 4..32.
- LEN_W, $clog2(WIDTH+1), width of cfg_length.
- DEFAULT_SEED, 1, seed used after reset; masked to the active length.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_length  in  LEN_W  active length n
- cfg_n_taps  in  1  0 = 2-tap polynomial, 1 = 4-tap polynomial
- cfg_galois  in  1  0 = Fibonacci, 1 = Galois
- run  in  1  1 = advance every cycle
- step  in  1  rising edge advances once while run=0
- seed_valid  in  1  seed offer
- seed_data  in  WIDTH  seed value
- seed_ready  out  1  seed accepted this cycle when high with seed_valid
- seed_err  out  1  one-cycle pulse: rejected all-zero seed
- out_value  out  WIDTH  current state; bits >= n are 0
- out_valid  out  1  configuration legal and state meaningful
- wrap  out  1  one-cycle pulse: state re-entered the current seed
- period_last  out  WIDTH  see Optional Feature

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values:
  - out_value = DEFAULT_SEED & lenmask(cfg_length at first edge), reset register value 1.
  - out_valid = 0, seed_ready = 0, seed_err = 0, wrap = 0, period_last = 0.
  - step_q = 0, seed register = DEFAULT_SEED.
- Polynomial mask P(n, n_taps): P[k-1] is set for each tap exponent k, including k = n; legal flag comes from the package.
- States:
  - INVALID: config illegal (n<2, n>WIDTH, or no entry). out_value=0, out_valid=0, seed_ready=0.
  - LOAD: one cycle. out_value <= seed & lenmask; wrap cleared. Entered from reset release, from INVALID when the config becomes legal, and on any change of {cfg_length, cfg_n_taps, cfg_galois} versus its registered copy.
  - ACTIVE: out_valid=1, seed_ready=1.
- Advance in ACTIVE when run=1, or when run=0 and step & ~step_q.
- Fibonacci advance: fb = ^(v & P); next = ((v<<1) | fb) & lenmask.
- Galois advance: fb = v[n-1]; next = ((v<<1) & lenmask) ^ (fb ? (((P<<1) & lenmask) | 1) : 0).
- Seed handshake has priority over advance.
- Accepted seed:
  - seed_data & lenmask != 0: store it and load it next cycle, with no advance that cycle.
  - seed_data & lenmask == 0: pulse seed_err, keep the old seed and state, advance proceeds normally.
- wrap: pulses in the cycle after an advance whose next value equals the stored seed & lenmask.
- Latency: advance decision to new out_value is 1 clk.
- Config going illegal moves to INVALID on the next edge; mid-sequence position is lost.
- Reset asserted mid-operation returns everything to reset values immediately.
- Lockup: state never becomes 0 in ACTIVE. If forced to 0 (e.g. SEU), reload the seed next cycle.

Optional Feature:
- Macro LFSR_GEN_PERIOD_CNT_EN.
- Defined: a WIDTH-bit counter clears on LOAD, increments per advance, and is captured into period_last on wrap. For n=4 the captured value is 15.
- Undefined: no counter; period_last is tied to 0.

Decomposition:
- Package lfsr_gen_pkg: tap table function taps(n, n_taps) returning {legal, P[31:0]}; lenmask function; state enum {INVALID, LOAD, ACTIVE}.
- Sub-module lfsr_gen_next: combinational next-state for both topologies, taking v, P, n and galois.

Test Plan:
- Reset, then n=4, Fibonacci, 2-tap, run=1 -> out_value 1,2,4,9,3,6,D,A,…,8,1; wrap pulses once after 15 advances; period_last=15 when the macro is defined.
- n=4, Galois, run=1 from seed 1 -> 1,2,4,8,9,B,F,…; period 15; wrap after 15 advances.
- run=0, step held high 5 cycles, then 3 separate pulses -> exactly 4 advances total.
- n=8 with cfg_n_taps=0 (no trinomial) -> out_valid=0, out_value=0, seed_ready=0. Switch cfg_n_taps=1 -> LOAD then out_value=1, out_valid=1.
- Seed 0x0010 with n=4 (masks to 0) -> seed_err pulse, sequence undisturbed. Then seed 0x5 -> next out_value 5, then continues 0xB.
- rst_n asserted mid-run at out_value 0xD -> outputs immediately go to reset values; resume from 1 after release.

Source files
------------

// File: rtl/lfsr_gen_pkg.sv
// lfsr_gen_pkg: state encoding, length masks and maximal-length tap tables
// shared by the LFSR generator and its next-state logic.
package lfsr_gen_pkg;

    typedef enum logic [1:0] {
        INVALID,
        LOAD,
        ACTIVE
    } lfsr_state_e;

    function automatic logic [31:0] lenmask(input int unsigned n);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] tapbit(input int unsigned k);
        return (k == 0) ? 32'd0 : (32'd1 << (k - 1));
    endfunction

    // Returns {legal, P}. Lengths with no primitive polynomial of the requested
    // weight (no trinomial, or 4-tap below n=5) come back illegal.
    function automatic logic [32:0] taps(input int unsigned n, input logic n_taps);
        int unsigned a, b, c, d;
        a = 0; b = 0; c = 0; d = 0;
        if (!n_taps) begin
            case (n)
                2:  begin a = 2;  b = 1;  end
                3:  begin a = 3;  b = 2;  end
                4:  begin a = 4;  b = 3;  end
                5:  begin a = 5;  b = 3;  end
                6:  begin a = 6;  b = 5;  end
                7:  begin a = 7;  b = 6;  end
                9:  begin a = 9;  b = 5;  end
                10: begin a = 10; b = 7;  end
                11: begin a = 11; b = 9;  end
                15: begin a = 15; b = 14; end
                17: begin a = 17; b = 14; end
                18: begin a = 18; b = 11; end
                20: begin a = 20; b = 17; end
                21: begin a = 21; b = 19; end
                22: begin a = 22; b = 21; end
                23: begin a = 23; b = 18; end
                25: begin a = 25; b = 22; end
                28: begin a = 28; b = 25; end
                29: begin a = 29; b = 27; end
                31: begin a = 31; b = 28; end
                default: ;
            endcase
        end else begin
            case (n)
                5:  begin a = 5;  b = 4;  c = 3;  d = 2;  end
                6:  begin a = 6;  b = 5;  c = 3;  d = 2;  end
                7:  begin a = 7;  b = 6;  c = 5;  d = 4;  end
                8:  begin a = 8;  b = 6;  c = 5;  d = 4;  end
                9:  begin a = 9;  b = 8;  c = 6;  d = 5;  end
                10: begin a = 10; b = 9;  c = 7;  d = 6;  end
                11: begin a = 11; b = 10; c = 9;  d = 7;  end
                12: begin a = 12; b = 6;  c = 4;  d = 1;  end
                13: begin a = 13; b = 4;  c = 3;  d = 1;  end
                14: begin a = 14; b = 5;  c = 3;  d = 1;  end
                15: begin a = 15; b = 14; c = 13; d = 11; end
                16: begin a = 16; b = 15; c = 13; d = 4;  end
                17: begin a = 17; b = 16; c = 15; d = 14; end
                18: begin a = 18; b = 17; c = 16; d = 13; end
                19: begin a = 19; b = 6;  c = 2;  d = 1;  end
                20: begin a = 20; b = 19; c = 16; d = 14; end
                21: begin a = 21; b = 20; c = 19; d = 16; end
                22: begin a = 22; b = 19; c = 18; d = 17; end
                23: begin a = 23; b = 22; c = 20; d = 18; end
                24: begin a = 24; b = 23; c = 22; d = 17; end
                25: begin a = 25; b = 24; c = 23; d = 22; end
                26: begin a = 26; b = 6;  c = 2;  d = 1;  end
                27: begin a = 27; b = 5;  c = 2;  d = 1;  end
                28: begin a = 28; b = 27; c = 24; d = 22; end
                29: begin a = 29; b = 28; c = 27; d = 25; end
                30: begin a = 30; b = 6;  c = 4;  d = 1;  end
                31: begin a = 31; b = 30; c = 29; d = 28; end
                32: begin a = 32; b = 22; c = 2;  d = 1;  end
                default: ;
            endcase
        end
        return {a != 0, tapbit(a) | tapbit(b) | tapbit(c) | tapbit(d)};
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: configuration, seed handshake and output bundle of lfsr_gen.
interface lfsr_gen_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic [LEN_W-1:0] cfg_length;
    logic             cfg_n_taps;
    logic             cfg_galois;
    logic             run;
    logic             step;
    logic             seed_valid;
    logic [WIDTH-1:0] seed_data;
    logic             seed_ready;
    logic             seed_err;
    logic [WIDTH-1:0] out_value;
    logic             out_valid;
    logic             wrap;
    logic [WIDTH-1:0] period_last;

    modport master (
        output cfg_length, cfg_n_taps, cfg_galois, run, step, seed_valid, seed_data,
        input  seed_ready, seed_err, out_value, out_valid, wrap, period_last
    );

    modport slave (
        input  cfg_length, cfg_n_taps, cfg_galois, run, step, seed_valid, seed_data,
        output seed_ready, seed_err, out_value, out_valid, wrap, period_last
    );
endinterface

// File: rtl/lfsr_gen_next.sv
// lfsr_gen_next: combinational successor of an n-bit LFSR state in either
// Fibonacci or Galois form.
module lfsr_gen_next
    import lfsr_gen_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_v,
    input  logic [WIDTH-1:0] i_poly,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_galois,
    output logic [WIDTH-1:0] o_next
);
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_fib;
    logic [WIDTH-1:0] w_gal;
    logic             w_fib_fb;
    logic             w_gal_fb;

    // The top active bit is isolated from the mask to avoid a variable index.
    assign w_mask   = WIDTH'(lenmask(32'(i_len)));
    assign w_top    = w_mask & ~(w_mask >> 1);
    assign w_fib_fb = ^(i_v & i_poly);
    assign w_gal_fb = |(i_v & w_top);
    assign w_fib    = ((i_v << 1) | {{(WIDTH-1){1'b0}}, w_fib_fb}) & w_mask;
    assign w_gal    = ((i_v << 1) & w_mask)
                    ^ (w_gal_fb ? (((i_poly << 1) & w_mask) | WIDTH'(1)) : '0);
    assign o_next   = i_galois ? w_gal : w_fib;
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: runtime-configurable maximal-length LFSR with seed handshake and wrap flag.
// Define LFSR_GEN_PERIOD_CNT_EN to capture the measured period into period_last.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int              WIDTH        = 16,
    parameter int              LEN_W        = $clog2(WIDTH + 1),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input logic       clk,
    input logic       rst_n,
    lfsr_gen_if.slave bus
);
    lfsr_state_e      r_state, w_state_nxt;
    logic [LEN_W+1:0] r_cfg, w_cfg;
    logic [WIDTH-1:0] r_value, r_seed;
    logic             r_step_q, r_seed_err, r_wrap;
    logic [32:0]      w_tap;
    logic [WIDTH-1:0] w_mask, w_poly, w_next, w_seed_m, w_load_val, w_in_seed_m;
    logic             w_legal, w_active, w_stay, w_seed_ok, w_seed_bad;
    logic             w_reload, w_adv, w_hit;

    assign w_tap       = taps(32'(bus.cfg_length), bus.cfg_n_taps);
    assign w_poly      = WIDTH'(w_tap);
    assign w_mask      = WIDTH'(lenmask(32'(bus.cfg_length)));
    assign w_legal     = w_tap[32] && (32'(bus.cfg_length) <= 32'(WIDTH));
    assign w_cfg       = {bus.cfg_length, bus.cfg_n_taps, bus.cfg_galois};
    assign w_active    = (r_state == ACTIVE);
    assign w_stay      = w_active && (w_state_nxt == ACTIVE);
    // A stored seed with no bits inside the active length would lock up; fall back to 1.
    assign w_seed_m    = r_seed & w_mask;
    assign w_load_val  = (w_seed_m != '0) ? w_seed_m : WIDTH'(1);
    assign w_in_seed_m = bus.seed_data & w_mask;
    assign w_seed_ok   = w_active && bus.seed_valid && (w_in_seed_m != '0);
    assign w_seed_bad  = w_active && bus.seed_valid && (w_in_seed_m == '0);
    assign w_reload    = w_stay && ((r_value == '0) || w_seed_ok);
    assign w_adv       = w_stay && !w_reload && (bus.run || (bus.step && !r_step_q));
    assign w_hit       = w_adv && (w_next == w_load_val);

    lfsr_gen_next #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_next (
        .i_v      (r_value),
        .i_poly   (w_poly),
        .i_len    (bus.cfg_length),
        .i_galois (bus.cfg_galois),
        .o_next   (w_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= LOAD;
        else        r_state <= w_state_nxt;
    end

    // LOAD ignores config changes because it samples the live config itself.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_legal) begin
            w_state_nxt = INVALID;
        end else begin
            case (r_state)
                INVALID: w_state_nxt = LOAD;
                LOAD:    w_state_nxt = ACTIVE;
                ACTIVE:  w_state_nxt = (w_cfg != r_cfg) ? LOAD : ACTIVE;
                default: w_state_nxt = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg      <= '0;
            r_value    <= DEFAULT_SEED;
            r_seed     <= DEFAULT_SEED;
            r_step_q   <= 1'b0;
            r_seed_err <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_cfg      <= w_cfg;
            r_step_q   <= bus.step;
            r_seed_err <= w_seed_bad;
            r_wrap     <= w_hit;
            if (w_seed_ok) r_seed <= bus.seed_data;
            if (r_state == LOAD && w_state_nxt == ACTIVE) r_value <= w_load_val;
            else if (w_seed_ok && w_stay)                 r_value <= w_in_seed_m;
            else if (w_reload)                            r_value <= w_load_val;
            else if (w_adv)                               r_value <= w_next;
        end
    end

`ifdef LFSR_GEN_PERIOD_CNT_EN
    logic [WIDTH-1:0] r_cnt, r_period_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_period_last <= '0;
        end else if (r_state == LOAD || w_reload) begin
            r_cnt <= '0;
        end else if (w_hit) begin
            r_cnt         <= '0;
            r_period_last <= r_cnt + WIDTH'(1);
        end else if (w_adv) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign bus.period_last = r_period_last;
`else
    assign bus.period_last = '0;
`endif

    assign bus.out_value  = (r_state == INVALID) ? '0 : (r_value & w_mask);
    assign bus.out_valid  = w_active;
    assign bus.seed_ready = w_active;
    assign bus.seed_err   = r_seed_err;
    assign bus.wrap       = r_wrap;
endmodule
